spike_rate_meter: RTL and testbench

Downstream consumer of the LIF neuron's spike output. Measures spike rate as spikes per window of neuron-update ticks (`en` strobes) and inter-spike interval (ISI) in ticks. Produces a latched rate with a one-cycle valid pulse per window, and an ISI with a one-cycle valid pulse per spike, for driving output pins or a debug readout.

---
 rtl/spike_rate_meter_if.sv | 34 +++
 rtl/spike_rate_meter.sv | 161 ++++++++++++++++
 tb/tb_spike_rate_meter.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/spike_rate_meter_if.sv
// Bus bundle between a spike source/controller and spike_rate_meter.
//   en         tick strobe (one clk wide), advances windows and ISI timer
//   run        measurement enable
//   spike      neuron spike level
//   rate       spike count of the last completed window
//   rate_valid one-cycle pulse when rate updates
//   rate_ovf   last completed window saturated its count
//   isi        ticks between the two most recent spikes
//   isi_valid  one-cycle pulse when isi updates
//   active     meter is counting
interface spike_rate_meter_if #(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned ISI_W = 16
);
  logic             en;
  logic             run;
  logic             spike;
  logic [CNT_W-1:0] rate;
  logic             rate_valid;
  logic             rate_ovf;
  logic [ISI_W-1:0] isi;
  logic             isi_valid;
  logic             active;

  modport master (
    output en, run, spike,
    input  rate, rate_valid, rate_ovf, isi, isi_valid, active
  );

  modport slave (
    input  en, run, spike,
    output rate, rate_valid, rate_ovf, isi, isi_valid, active
  );
endinterface

// File: rtl/spike_rate_meter.sv
// Spike rate / inter-spike-interval meter for the LIF neuron output.
// Counts rising edges of `spike` over windows of WINDOW_TICKS `en` ticks and
// measures the number of `en` ticks between consecutive spikes.
// Ports:
//   clk  clock (single domain)
//   rst  synchronous reset, active-high
//   bus  spike_rate_meter_if.slave: en/run/spike in; rate, rate_valid,
//        rate_ovf, isi, isi_valid, active out (all registered)
module spike_rate_meter #(
  parameter int unsigned WINDOW_TICKS = 256,
  parameter int unsigned CNT_W        = 8,
  parameter int unsigned ISI_W        = 16
) (
  input logic               clk,
  input logic               rst,
  spike_rate_meter_if.slave bus
);

  localparam int unsigned       TICK_W    = $clog2(WINDOW_TICKS);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(WINDOW_TICKS - 1);
  localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [ISI_W-1:0]  ISI_MAX   = '1;
  localparam logic [ISI_W-1:0]  ISI_ONE   = ISI_W'(1);

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [CNT_W-1:0]  spk_q, spk_d;
  logic              sat_q, sat_d;
  logic [ISI_W-1:0]  tmr_q, tmr_d;
  logic              seen_q, seen_d;
  logic              spike_q;
  logic [CNT_W-1:0]  rate_q, rate_d;
  logic              rate_valid_q, rate_valid_d;
  logic              rate_ovf_q, rate_ovf_d;
  logic [ISI_W-1:0]  isi_q, isi_d;
  logic              isi_valid_q, isi_valid_d;

  logic spike_edge;
  logic win_close;

  assign spike_edge = bus.spike & ~spike_q;
  assign win_close  = bus.en && (tick_q == TICK_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      tick_q       <= '0;
      spk_q        <= '0;
      sat_q        <= 1'b0;
      tmr_q        <= '0;
      seen_q       <= 1'b0;
      spike_q      <= 1'b0;
      rate_q       <= '0;
      rate_valid_q <= 1'b0;
      rate_ovf_q   <= 1'b0;
      isi_q        <= '0;
      isi_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      tick_q       <= tick_d;
      spk_q        <= spk_d;
      sat_q        <= sat_d;
      tmr_q        <= tmr_d;
      seen_q       <= seen_d;
      spike_q      <= bus.spike;
      rate_q       <= rate_d;
      rate_valid_q <= rate_valid_d;
      rate_ovf_q   <= rate_ovf_d;
      isi_q        <= isi_d;
      isi_valid_q  <= isi_valid_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    tick_d       = tick_q;
    spk_d        = spk_q;
    sat_d        = sat_q;
    tmr_d        = tmr_q;
    seen_d       = seen_q;
    rate_d       = rate_q;
    rate_valid_d = 1'b0;
    rate_ovf_d   = rate_ovf_q;
    isi_d        = isi_q;
    isi_valid_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        tick_d = '0;
        spk_d  = '0;
        sat_d  = 1'b0;
        tmr_d  = '0;
        seen_d = 1'b0;
        if (bus.run) state_d = COUNT;
      end

      COUNT: begin
        if (spike_edge) begin
          if (spk_q != CNT_MAX) spk_d = spk_q + CNT_ONE;
          else                  sat_d = 1'b1;
        end

        // The close overrides the increment above: an edge in the closing
        // cycle is folded into the published rate, not the next window.
        if (win_close) begin
          rate_d       = (spike_edge && spk_q != CNT_MAX) ? spk_q + CNT_ONE : spk_q;
          rate_ovf_d   = sat_q | ((spk_q == CNT_MAX) & spike_edge);
          rate_valid_d = 1'b1;
          tick_d       = '0;
          spk_d        = '0;
          sat_d        = 1'b0;
        end else if (bus.en) begin
          tick_d = tick_q + TICK_ONE;
        end

        // ISI: a coincident tick is not added; the pre-increment value is
        // reported and the timer restarts from zero.
        if (spike_edge) begin
          if (seen_q) begin
            isi_d       = tmr_q;
            isi_valid_d = 1'b1;
          end
          tmr_d  = '0;
          seen_d = 1'b1;
        end else if (bus.en && tmr_q != ISI_MAX) begin
          tmr_d = tmr_q + ISI_ONE;
        end

        // Abort discards the partial window and the ISI in flight, but a
        // window closing in this very cycle is still published.
        if (!bus.run) begin
          state_d     = IDLE;
          tick_d      = '0;
          spk_d       = '0;
          sat_d       = 1'b0;
          tmr_d       = '0;
          seen_d      = 1'b0;
          isi_d       = isi_q;
          isi_valid_d = 1'b0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.rate       = rate_q;
  assign bus.rate_valid = rate_valid_q;
  assign bus.rate_ovf   = rate_ovf_q;
  assign bus.isi        = isi_q;
  assign bus.isi_valid  = isi_valid_q;
  assign bus.active     = (state_q == COUNT);

endmodule

// File: tb/tb_spike_rate_meter.sv
module tb_spike_rate_meter;

  localparam int unsigned WINDOW_TICKS = 4;
  localparam int unsigned CNT_W        = 2;
  localparam int unsigned ISI_W        = 16;

  logic clk;
  logic rst;

  int unsigned n_checks;
  int unsigned n_errors;
  int unsigned rv_cnt;
  int unsigned iv_cnt;

  spike_rate_meter_if #(.CNT_W(CNT_W), .ISI_W(ISI_W)) bus ();

  spike_rate_meter #(
    .WINDOW_TICKS(WINDOW_TICKS),
    .CNT_W       (CNT_W),
    .ISI_W       (ISI_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input longint unsigned got, input longint unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Apply one cycle of inputs; outputs are sampled 1 time unit after the edge.
  task automatic cycle(input logic en_v, input logic spike_v);
    bus.en    = en_v;
    bus.spike = spike_v;
    @(posedge clk);
    #1;
    rv_cnt += int'(bus.rate_valid);
    iv_cnt += int'(bus.isi_valid);
  endtask

  // One full 16-clk window, en on every 4th clk; spike level follows mask.
  task automatic window(input logic [15:0] mask, input string tag,
                        input int unsigned exp_rate, input logic exp_ovf);
    rv_cnt = 0;
    for (int k = 0; k < 15; k++) cycle((k % 4) == 3, mask[k]);
    check({tag, "_no_early_rv"}, rv_cnt, 0);
    cycle(1'b1, mask[15]);
    check({tag, "_rate_valid"}, bus.rate_valid, 1);
    check({tag, "_rate"}, bus.rate, exp_rate);
    check({tag, "_ovf"}, bus.rate_ovf, exp_ovf);
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rv_cnt    = 0;
    iv_cnt    = 0;
    rst       = 1'b1;
    bus.run   = 1'b0;
    bus.en    = 1'b0;
    bus.spike = 1'b0;

    // Reset with spike toggling.
    cycle(1'b0, 1'b1);
    cycle(1'b1, 1'b0);
    check("rst_rate", bus.rate, 0);
    check("rst_rate_valid", bus.rate_valid, 0);
    check("rst_rate_ovf", bus.rate_ovf, 0);
    check("rst_isi", bus.isi, 0);
    check("rst_isi_valid", bus.isi_valid, 0);
    check("rst_active", bus.active, 0);

    // Idle: run low, inputs wiggle, nothing happens.
    rst    = 1'b0;
    rv_cnt = 0;
    iv_cnt = 0;
    for (int k = 0; k < 6; k++) cycle(k[0], ~k[1]);
    check("idle_active", bus.active, 0);
    check("idle_rv", rv_cnt, 0);
    check("idle_iv", iv_cnt, 0);
    check("idle_rate", bus.rate, 0);
    cycle(1'b0, 1'b0);

    // Enter COUNT.
    bus.run = 1'b1;
    cycle(1'b0, 1'b0);
    check("run_active", bus.active, 1);

    // Three 4-clk pulses in one window.
    window(16'hF3CF, "basic", 3, 1'b0);
    // Rising edge coincident with the closing tick.
    window(16'h8000, "boundary", 1, 1'b0);
    // Spike held over from previous window: no new edge.
    window(16'h0007, "empty", 0, 1'b0);
    // Five edges, count saturates at 3.
    window(16'h0155, "sat", 3, 1'b1);
    // Overflow flag clears on a normal window.
    window(16'h0002, "after_sat", 1, 1'b0);
    rv_cnt = 0;
    cycle(1'b0, 1'b0);
    check("pulse_one_cycle", rv_cnt, 0);

    // Leave and re-enter COUNT so the first-spike rule applies afresh.
    bus.run = 1'b0;
    cycle(1'b0, 1'b0);
    check("stop_active", bus.active, 0);
    bus.run = 1'b1;
    cycle(1'b0, 1'b0);

    // ISI: spikes on even clks, ticks on odd clks.
    iv_cnt = 0;
    cycle(1'b0, 1'b1);
    check("isi_first_no_valid", iv_cnt, 0);
    for (int i = 1; i <= 13; i++) cycle(i[0], 1'b0);
    cycle(1'b0, 1'b1);
    check("isi7_valid", bus.isi_valid, 1);
    check("isi7", bus.isi, 7);
    cycle(1'b1, 1'b0);
    check("isi_pulse_one_cycle", bus.isi_valid, 0);
    cycle(1'b0, 1'b0);
    cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b1);
    check("isi2_valid", bus.isi_valid, 1);
    check("isi2", bus.isi, 2);
    // Spike coincident with a tick reports the pre-increment timer.
    cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b0);
    cycle(1'b1, 1'b1);
    check("isi_coincident", bus.isi, 1);
    // Timer saturation.
    for (int i = 0; i < 70000; i++) cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b1);
    check("isi_sat_valid", bus.isi_valid, 1);
    check("isi_sat", bus.isi, 65535);
    cycle(1'b0, 1'b0);

    // Abort mid-window.
    bus.run = 1'b0;
    cycle(1'b0, 1'b0);
    bus.run = 1'b1;
    cycle(1'b0, 1'b0);
    rv_cnt = 0;
    for (int k = 0; k < 8; k++) cycle((k % 4) == 3, k == 1);
    bus.run = 1'b0;
    cycle(1'b0, 1'b0);
    check("abort_active", bus.active, 0);
    check("abort_no_rv", rv_cnt, 0);
    cycle(1'b0, 1'b0);
    check("abort_still_no_rv", rv_cnt, 0);

    // Resume: partial window was discarded.
    bus.run = 1'b1;
    cycle(1'b0, 1'b0);
    window(16'h0020, "resume", 1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
